ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Shares the dual-port RAM (one write port, one read port, 16x8) between NUM_REQ requesters.
//  Writes and reads are arbitrated independently; each uses its own round-robin arbiter.
//  Blocks a same-cycle write/read to the same address; routes read data back to the issuer.
//  Sits between the requester agents and the RAM's wr_*/rd_* pins.
// PARAMETERS
//  NUM_REQ  2  number of requesters (>=2)
//  ADDR_W   4  RAM address width
//  DATA_W   8  RAM data width
//  RD_LAT   1  RAM read latency, cycles from rd_enb sampled to rd_data valid (>=1)
// PORTS
//  clk        in   1               single clock, all logic on posedge
//  rst        in   1               asynchronous, active-low reset
//  req_valid  in   NUM_REQ         requester i has a request
//  req_we     in   NUM_REQ         1 = write, 0 = read
//  req_addr   in   NUM_REQ*ADDR_W  packed, slice i = requester i
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  req_ready  out  NUM_REQ         request accepted this cycle (combinational)
//  rsp_valid  out  NUM_REQ         read data for requester i on rsp_rdata
//  rsp_rdata  out  DATA_W          read data, shared by all requesters
//  wr_enb     out  1               RAM write enable (registered)
//  wr_addr    out  ADDR_W          RAM write address
//  wr_data    out  DATA_W          RAM write data
//  rd_enb     out  1               RAM read enable (registered)
//  rd_addr    out  ADDR_W          RAM read address
//  rd_data    in   DATA_W          RAM read data
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0; req_ready=0; round-robin pointers favour requester 0;
//    the response pipeline is cleared. Reset mid-operation drops in-flight reads (no rsp_valid).
//  - Handshake: a request is accepted when req_valid[i] & req_ready[i] at a posedge.
//    Requesters hold valid/we/addr/wdata stable until accepted.
//  - Write arb: selects among valid & we. Read arb: selects among valid & ~we.
//    One write grant and one read grant are allowed in the same cycle (different requesters).
//  - Round-robin: priority starts at (last granted + 1) mod NUM_REQ.
//    Each arbiter's pointer updates only on its own accepted grant.
//  - Hazard: if the write grant and read grant in a cycle have equal addr, the read ready is
//    withheld for that cycle. The write proceeds; the read is granted next cycle or later and
//    returns the new data. The read pointer does not advance.
//  - Latency: an accept at edge t drives wr_*/rd_* for cycle t+1. wr_enb/rd_enb are high for
//    exactly 1 cycle per accept; when idle, addr/data outputs hold their last value.
//  - Read return: a requester-id/valid shift register of depth RD_LAT tracks each read.
//    rsp_valid[id] = 1 for 1 cycle, RD_LAT cycles after rd_enb, with rsp_rdata = rd_data.
//    Back-to-back reads give back-to-back responses.
//  - Reads with no contention sustain 1 read/cycle; writes sustain 1 write/cycle.
// STRUCTURE
//  - ram_arb_pkg: ADDR_W/DATA_W/RD_LAT defaults; req_t struct {we, addr, wdata};
//    function clog2-based ID_W.
//  - Sub-module rr_arbiter (req vector in, one-hot grant out, pointer update on accept).
//    Instantiated twice, for write and read; hazard masking and the response pipe live in the top.
// TESTING
//  1. rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, wr_enb=rd_enb=0, rsp_valid=0.
//  2. Req0 write addr 3 data 8'hA5 -> ready0 same cycle; next cycle wr_enb=1,
//     wr_addr=3, wr_data=A5 for 1 cycle.
//  3. Req0 and req1 both write continuously (addr 1, 2) -> grants alternate 0,1,0,1,
//     with 1 write per cycle.
//  4. Req0 write addr 5 data 3C + req1 read addr 5 same cycle -> ready1 low that cycle,
//     granted next; rsp_valid[1] returns 3C.
//  5. Req0 read addr 2 (holding 8'h11) + req1 write addr 7 same cycle -> both ready;
//     rsp_valid[0]=1 with 11 at RD_LAT after rd_enb.
//  6. Req1 read accepted, then rst=0 before rd_data returns -> no rsp_valid after reset;
//     the next accept is served by requester 0 first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RAM access arbiter.
//   DEF_*   : default geometry (2 requesters, 16x8 RAM, 1-cycle read latency)
//   req_t   : one requester's command {we, addr, wdata} at default widths
//   id_w()  : width of a requester id, never narrower than 1 bit
package ram_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_LAT  = 1;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (pointer returns to requester 0)
//   i_req      : request vector
//   i_accept   : the current grant was taken this cycle; advance the pointer
//   o_gnt      : one-hot grant (all zero when nothing requests)
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);

  localparam int PW = id_w(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gnt_idx;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  int            w_idx;

  // Scan from the pointer upward with wrap; first requester seen wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_gnt[w_idx]   = 1'b1;
        w_gnt_idx      = PW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (i_accept) r_ptr <= (w_gnt_idx == PW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a 1W/1R RAM among NUM_REQ requesters. Writes and reads each have
// their own round-robin arbiter; a read colliding with the same-cycle write
// address is held off a cycle so it observes the new data. Read responses are
// routed back by a requester-id shift register matched to RD_LAT.
//   clk, rst              : clock, async active-low reset
//   req_valid/we/addr/wdata: per-requester command (addr/wdata packed by slice)
//   req_ready             : combinational accept
//   rsp_valid, rsp_rdata  : read return, one-hot valid, shared data
//   wr_enb/addr/data      : registered RAM write port
//   rd_enb/addr, rd_data  : registered RAM read port, returned data
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      wr_enb,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      rd_enb,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rd_data
);

  localparam int ID_W = id_w(NUM_REQ);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_s;

  req_s                 w_req [NUM_REQ];
  logic [NUM_REQ-1:0]   w_wr_req, w_rd_req, w_wr_gnt, w_rd_gnt;
  logic [ADDR_W-1:0]    w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0]    w_wr_data;
  logic [ID_W-1:0]      w_rd_id;
  logic                 w_haz, w_wr_acc, w_rd_acc;

  logic                 r_wr_enb;
  logic [ADDR_W-1:0]    r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0]    r_wr_data;
  // Stage 0 is the registered rd_enb; stage RD_LAT lines up with rd_data.
  logic [RD_LAT:0]           r_vld_pipe;
  logic [RD_LAT:0][ID_W-1:0] r_id_pipe;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_req[g]      = '{we:    req_we[g],
                             addr:  req_addr[g*ADDR_W +: ADDR_W],
                             wdata: req_wdata[g*DATA_W +: DATA_W]};
    assign w_wr_req[g]   = req_valid[g] &  w_req[g].we;
    assign w_rd_req[g]   = req_valid[g] & ~w_req[g].we;
    assign req_ready[g]  = rst & (w_wr_gnt[g] | (w_rd_gnt[g] & ~w_haz));
    assign rsp_valid[g]  = r_vld_pipe[RD_LAT] & (r_id_pipe[RD_LAT] == ID_W'(g));
  end

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (w_wr_req),
    .i_accept (w_wr_acc),
    .o_gnt    (w_wr_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (w_rd_req),
    .i_accept (w_rd_acc),
    .o_gnt    (w_rd_gnt)
  );

  // One-hot grant -> selected command fields.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    w_rd_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_gnt[i]) begin
        w_wr_addr = w_req[i].addr;
        w_wr_data = w_req[i].wdata;
      end
      if (w_rd_gnt[i]) begin
        w_rd_addr = w_req[i].addr;
        w_rd_id   = ID_W'(i);
      end
    end
  end

  // Same-address write/read: let the write go first so the deferred read sees it.
  assign w_haz    = (|w_wr_gnt) & (|w_rd_gnt) & (w_wr_addr == w_rd_addr);
  assign w_wr_acc = rst & (|w_wr_gnt);
  assign w_rd_acc = rst & (|w_rd_gnt) & ~w_haz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_enb   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_wr_enb <= w_wr_acc;
      if (w_wr_acc) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= w_wr_data;
      end
      if (w_rd_acc) r_rd_addr <= w_rd_addr;
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_acc};
      r_id_pipe  <= {r_id_pipe[RD_LAT-1:0], w_rd_id};
    end
  end

  assign wr_enb    = r_wr_enb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_enb    = r_vld_pipe[0];
  assign rd_addr   = r_rd_addr;
  assign rsp_rdata = r_vld_pipe[RD_LAT] ? rd_data : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, wr_data, rd_data;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic            wr_enb, rd_enb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_enb    (wr_enb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_enb    (rd_enb),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // 16x8 RAM, write on edge, read data one cycle after rd_enb.
  logic [DW-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rd_data = '0;
  end
  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= wr_data;
    if (rd_enb) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  logic [N-1:0] exp_gnt [4];

  initial begin
    rst = 1'b0; req_valid = '1; req_we = '1; req_addr = '0; req_wdata = '0;

    // Reset with everyone requesting: nothing accepted, nothing driven.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_wr_enb", wr_enb, 0);
      check("rst_rd_enb", rd_enb, 0);
      check("rst_rsp", rsp_valid, 0);
    end
    cyc();
    rst = 1'b1; req_valid = '0;
    cyc();

    // Single write.
    set_req(0, 1'b1, 4'd3, 8'hA5);
    @(negedge clk); check("w1_ready", req_ready, 2'b01);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("w1_enb", wr_enb, 1); check("w1_addr", wr_addr, 3); check("w1_data", wr_data, 8'hA5);
    cyc();
    @(negedge clk); check("w1_enb_off", wr_enb, 0); check("w1_addr_hold", wr_addr, 3);
    cyc();

    // Two continuous writers; last write grant was 0, so 1 leads.
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    set_req(0, 1'b1, 4'd1, 8'h10);
    set_req(1, 1'b1, 4'd2, 8'h11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_ready", req_ready, exp_gnt[k]);
      if (k > 0) begin
        check("rr_enb", wr_enb, 1);
        check("rr_addr", wr_addr, exp_gnt[k-1][1] ? 2 : 1);
      end
      cyc();
    end
    req_valid = '0;
    @(negedge clk); check("rr_enb_last", wr_enb, 1); check("rr_addr_last", wr_addr, 1);
    cyc();

    // Same-address write/read: read deferred, returns new data.
    set_req(0, 1'b1, 4'd5, 8'h3C);
    set_req(1, 1'b0, 4'd5, 8'h00);
    @(negedge clk); check("haz_ready", req_ready, 2'b01);
    cyc(); req_valid[0] = 1'b0;
    @(negedge clk);
    check("haz_ready2", req_ready, 2'b10); check("haz_wr_enb", wr_enb, 1);
    check("haz_wr_addr", wr_addr, 5); check("haz_rd_enb0", rd_enb, 0);
    cyc(); req_valid = '0;
    @(negedge clk); check("haz_rd_enb", rd_enb, 1); check("haz_rd_addr", rd_addr, 5);
    cyc();
    @(negedge clk); check("haz_rsp", rsp_valid, 2'b10); check("haz_rdata", rsp_rdata, 8'h3C);
    cyc();

    // Read and write on different addresses in parallel.
    set_req(0, 1'b0, 4'd2, 8'h00);
    set_req(1, 1'b1, 4'd7, 8'h77);
    @(negedge clk); check("par_ready", req_ready, 2'b11);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("par_rd_enb", rd_enb, 1); check("par_rd_addr", rd_addr, 2);
    check("par_wr_enb", wr_enb, 1); check("par_wr_addr", wr_addr, 7); check("par_wr_data", wr_data, 8'h77);
    cyc();
    @(negedge clk); check("par_rsp", rsp_valid, 2'b01); check("par_rdata", rsp_rdata, 8'h11);
    cyc();

    // Back-to-back reads; last read grant was 0, so 1 leads.
    set_req(0, 1'b0, 4'd3, 8'h00);
    set_req(1, 1'b0, 4'd7, 8'h00);
    @(negedge clk); check("b2b_ready1", req_ready, 2'b10);
    cyc(); req_valid[1] = 1'b0;
    @(negedge clk); check("b2b_ready0", req_ready, 2'b01); check("b2b_rd_addr1", rd_addr, 7);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("b2b_rsp1", rsp_valid, 2'b10); check("b2b_rdata1", rsp_rdata, 8'h77);
    check("b2b_rd_addr0", rd_addr, 3);
    cyc();
    @(negedge clk); check("b2b_rsp0", rsp_valid, 2'b01); check("b2b_rdata0", rsp_rdata, 8'hA5);
    cyc();
    @(negedge clk); check("b2b_idle_rsp", rsp_valid, 0); check("b2b_idle_rd", rd_enb, 0);
    cyc();

    // Reset with a read in flight; write pointer is left favouring 1 before reset.
    set_req(0, 1'b1, 4'd9, 8'h99);
    set_req(1, 1'b0, 4'd1, 8'h00);
    @(negedge clk); check("rr6_ready", req_ready, 2'b11);
    cyc(); req_valid = '0; rst = 1'b0;
    #1; check("rr6_rd_enb_clr", rd_enb, 0); check("rr6_wr_enb_clr", wr_enb, 0);
    cyc();
    @(negedge clk); check("rr6_rsp_drop", rsp_valid, 0);
    cyc(); rst = 1'b1;
    set_req(0, 1'b1, 4'd4, 8'h44);
    set_req(1, 1'b1, 4'd6, 8'h66);
    @(negedge clk); check("rr6_ptr_reset", req_ready, 2'b01); check("rr6_rsp_none", rsp_valid, 0);
    cyc(); req_valid = '0;
    @(negedge clk); check("rr6_wr_addr", wr_addr, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
